// File: rtl/wisc_pkg.sv
// rtl/wisc_pkg.sv - shared WISC-S25 pipeline types and constants
package wisc_pkg;

    localparam logic [15:0] NOP_INSTR          = 16'h0000;
    localparam logic [3:0]  HLT_OPCODE_DEFAULT = 4'hF;

    typedef enum logic [1:0] {
        RUN          = 2'd0,
        HALT_FETCHED = 2'd1,
        HALTED       = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [15:0] pc_curr;
        logic [15:0] pc_next;
        logic [15:0] instr;
        logic [1:0]  prediction;
        logic [15:0] predicted_target;
        logic        valid;
    } if_id_t;

endpackage

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - fetch stage connections to hazard unit, decode, predictor and imem
interface fetch_stage_if;

    logic        stall_PC;
    logic        stall_IF_ID;
    logic        branch_mispredicted;
    logic        actual_taken;
    logic [15:0] actual_target;
    logic [1:0]  prediction;
    logic [15:0] predicted_target;
    logic [15:0] instr;

    logic [15:0] PC_curr;
    logic        PC_enable;
    logic [15:0] IF_ID_PC_curr;
    logic [15:0] IF_ID_PC_next;
    logic [15:0] IF_ID_instr;
    logic [1:0]  IF_ID_prediction;
    logic [15:0] IF_ID_predicted_target;
    logic        IF_ID_valid;
    logic        halted;

    modport master (
        input  stall_PC, stall_IF_ID, branch_mispredicted, actual_taken, actual_target,
               prediction, predicted_target, instr,
        output PC_curr, PC_enable, IF_ID_PC_curr, IF_ID_PC_next, IF_ID_instr,
               IF_ID_prediction, IF_ID_predicted_target, IF_ID_valid, halted
    );

    modport slave (
        output stall_PC, stall_IF_ID, branch_mispredicted, actual_taken, actual_target,
               prediction, predicted_target, instr,
        input  PC_curr, PC_enable, IF_ID_PC_curr, IF_ID_PC_next, IF_ID_instr,
               IF_ID_prediction, IF_ID_predicted_target, IF_ID_valid, halted
    );

endinterface

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with flush, stall and bubble controls
module if_id_reg
    import wisc_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   flush,
    input  logic   stall,
    input  logic   bubble,
    input  if_id_t d,
    output if_id_t q
);

    localparam if_id_t FLUSH_VAL = '{
        pc_curr:          16'h0000,
        pc_next:          16'h0000,
        instr:            NOP_INSTR,
        prediction:       2'b00,
        predicted_target: 16'h0000,
        valid:            1'b0
    };

    // A bubble only drops valid; the stale payload is harmless once invalid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (flush) begin
            q <= FLUSH_VAL;
        end else if (stall) begin
            q <= q;
        end else if (bubble) begin
            q.valid <= 1'b0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - IF stage: PC register, next-PC select, HLT state machine, IF/ID register
module fetch_stage
    import wisc_pkg::*;
#(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter logic [3:0]  HLT_OPCODE = HLT_OPCODE_DEFAULT
) (
    input logic          clk,
    input logic          rst_n,
    fetch_stage_if.master fif
);

    fetch_state_t state, state_next;
    logic [15:0]  pc_q, pc_d, pc_plus2, redirect_target;
    logic         redirect, running, capture, advance, hlt_detect, pc_en;
    if_id_t       if_id_d, if_id_q;

    assign running         = (state == RUN);
    // Once committed to HALTED, late squashes from decode must not revive fetch.
    assign redirect        = fif.branch_mispredicted & (state != HALTED);
    assign pc_plus2        = pc_q + 16'd2;
    assign redirect_target = fif.actual_taken ? fif.actual_target : if_id_q.pc_next;
    assign capture         = ~redirect & ~fif.stall_IF_ID & running;
    assign advance         = ~redirect & ~fif.stall_IF_ID;
    assign hlt_detect      = capture & (fif.instr[15:12] == HLT_OPCODE);
    assign pc_en           = redirect | (~fif.stall_PC & running);

    always_comb begin
        pc_d = pc_q;
        if (redirect) begin
            pc_d = redirect_target;
        end else if (fif.stall_PC || !running || hlt_detect) begin
            pc_d = pc_q;
        end else if (fif.prediction[1]) begin
            pc_d = fif.predicted_target;
        end else begin
            pc_d = pc_plus2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // HLT becomes final only after it leaves decode without being squashed.
    always_comb begin
        state_next = state;
        case (state)
            RUN:          if (hlt_detect) state_next = HALT_FETCHED;
            HALT_FETCHED: begin
                if (redirect)     state_next = RUN;
                else if (advance) state_next = HALTED;
            end
            HALTED:       state_next = HALTED;
            default:      state_next = RUN;
        endcase
    end

    always_comb begin
        if_id_d = '{
            pc_curr:          pc_q,
            pc_next:          pc_plus2,
            instr:            fif.instr,
            prediction:       fif.prediction,
            predicted_target: fif.predicted_target,
            valid:            1'b1
        };
    end

    if_id_reg u_if_id_reg (
        .clk    (clk),
        .rst_n  (rst_n),
        .flush  (redirect),
        .stall  (fif.stall_IF_ID),
        .bubble (~running),
        .d      (if_id_d),
        .q      (if_id_q)
    );

    assign fif.PC_curr                = pc_q;
    assign fif.PC_enable              = pc_en;
    assign fif.IF_ID_PC_curr          = if_id_q.pc_curr;
    assign fif.IF_ID_PC_next          = if_id_q.pc_next;
    assign fif.IF_ID_instr            = if_id_q.instr;
    assign fif.IF_ID_prediction       = if_id_q.prediction;
    assign fif.IF_ID_predicted_target = if_id_q.predicted_target;
    assign fif.IF_ID_valid            = if_id_q.valid;
    assign fif.halted                 = (state == HALTED);

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- IF stage of the 5-stage WISC-S25 pipeline.
- Holds the PC register and selects the next PC from three sources: the decode-stage mispredict redirect, the DynamicBranchPredictor's predicted target, or PC+2.
- Drives the IF/ID pipeline register that feeds decode and the predictor's update port.
- Adds stall and flush handling, plus a HLT-detect state machine that freezes fetch.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset.
HLT_OPCODE, 4'hF, instr[15:12] encoding of HLT.

Ports:
clk  in  1  system clock
rst_n  in  1  reset
stall_PC  in  1  hazard unit: hold PC
stall_IF_ID  in  1  hazard unit: hold IF/ID register
branch_mispredicted  in  1  from decode, already qualified by was_branch
actual_taken  in  1  from decode: resolved direction
actual_target  in  16  from decode: resolved taken target
prediction  in  2  from DBP for PC_curr; bit[1] = predict taken
predicted_target  in  16  from DBP for PC_curr
instr  in  16  imem read data for PC_curr (combinational read)
PC_curr  out  16  current PC, to imem and to DBP (which uses bits [3:0])
PC_enable  out  1  DBP enable (= PC register write enable)
IF_ID_PC_curr  out  16  PC of the instruction in decode
IF_ID_PC_next  out  16  fall-through PC (PC+2) of the instruction in decode
IF_ID_instr  out  16  instruction in decode
IF_ID_prediction  out  2  prediction carried with the instruction
IF_ID_predicted_target  out  16  predicted target carried with the instruction
IF_ID_valid  out  1  0 = bubble
halted  out  1  fetch permanently stopped

Behaviour:
Clock and reset
- One clock, clk.
- Reset is asynchronous and active-low on rst_n.
- On reset: PC_curr = RESET_PC, all IF_ID_* = 0 (IF_ID_valid = 0), state = RUN, halted = 0.

PC arithmetic
- PC_plus2 = PC_curr + 2, mod 2^16. 16'hFFFE wraps to 16'h0000.

Redirect
- redirect_target = actual_taken ? actual_target : IF_ID_PC_next.
- This covers a predicted-taken branch that resolves not-taken.

Next-PC selection, in priority order:
1. branch_mispredicted: load redirect_target. Overrides stall_PC and any halt state except HALTED.
2. stall_PC, or state != RUN: hold.
3. prediction[1]: load predicted_target.
4. Otherwise: load PC_plus2.

PC_enable
- PC_enable = branch_mispredicted | (~stall_PC & state == RUN).

IF/ID register, in priority order:
1. branch_mispredicted (flush): valid = 0, instr = NOP_INSTR, prediction = 2'b00, other fields = 0. Flush beats stall_IF_ID.
2. stall_IF_ID: hold all fields.
3. state != RUN: insert a bubble (valid = 0).
4. Otherwise: capture PC_curr, PC_plus2, instr, prediction, predicted_target, and valid = 1.

Latency
- One cycle from PC_curr to the IF_ID_* outputs.
- A mispredict costs one bubble: the wrong-path fetch in IF is squashed, and the correct PC is fetched on the next cycle.

State machine, 2-bit
- RUN → HALT_FETCHED: instr[15:12] == HLT_OPCODE, and IF/ID captures it (not flushed, not stalled). The PC then holds at the HLT address.
- HALT_FETCHED → RUN: branch_mispredicted (the HLT was on the wrong path). The PC loads redirect_target that same cycle.
- HALT_FETCHED → HALTED: the next cycle in which IF/ID advances without flush. HLT has left decode, so it is committed against branch squash.
- HALTED: terminal until reset.
  - halted = 1.
  - PC frozen.
  - Bubbles issued.
  - branch_mispredicted ignored.

Other boundary cases
- Reset asserted mid-stall or mid-halt: immediate asynchronous return to reset values.
- An imem X on instr is captured as-is. No checking in this block.

Decomposition:
- Shared package wisc_pkg:
  - NOP_INSTR = 16'h0000
  - HLT_OPCODE default
  - fetch_state_t enum {RUN, HALT_FETCHED, HALTED}
  - IF_ID struct type: pc_curr, pc_next, instr, prediction, predicted_target, valid
- Sub-module if_id_reg: the IF/ID pipeline register with stall/flush/bubble controls, reused by the pipeline top.
- PC register, next-PC mux and FSM live in fetch_stage.

Test Plan:
1. Reset release, no stalls, prediction = 00, instr = 16'h1234 → PC sequence 0000, 0002, 0004. The cycle after each PC, IF_ID_PC_curr equals it with IF_ID_valid = 1.
2. PC = 0x0004, prediction = 2'b11, predicted_target = 0x0040 → next PC = 0x0040. IF_ID_prediction = 11 and IF_ID_predicted_target = 0x0040 for the 0x0004 instruction.
3. Mispredict case with the IF_ID_PC_next = 0x0006 instruction in decode, branch_mispredicted = 1:
   - actual_taken = 1, actual_target = 0x0100 → PC = 0x0100, IF_ID_valid = 0, IF_ID_instr = 0.
   - actual_taken = 0, same branch → PC = 0x0006.
4. stall_PC = stall_IF_ID = 1 for 3 cycles at PC 0x0008 → PC_enable = 0 and all IF_ID_* unchanged. branch_mispredicted pulsed during the stall → redirect and flush occur anyway.
5. HLT (16'hF000) fetched at 0x000A:
   - PC holds 0x000A.
   - With no flush on the next cycle, halted = 1 and then stays 1.
   - With a mispredict (target 0x0020) on the next cycle instead: state = RUN, PC = 0x0020, halted stays 0.
6. PC = 0xFFFE, no prediction → PC wraps to 0x0000. rst_n pulled low mid-cycle → PC_curr = 0x0000 and IF_ID_valid = 0 immediately, without waiting for a clock edge.
